// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters (IDLE->EXEC->RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 4     // EXEC cycles for control code 3; must be >= 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [3:0]        req0_ctrl_i,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [3:0]        req1_ctrl_i,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,

    output logic [3:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o
);

    localparam int               CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [3:0]       CTRL_MUL = 4'd3;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;

    logic              grant_valid;
    logic              grant_id;
    logic [3:0]        sel_ctrl;
    logic [DATA_W-1:0] sel_src1;
    logic [DATA_W-1:0] sel_src2;

    // Grant is evaluated only in IDLE, so ready can never rise while an op or response is in flight.
    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (req0_valid_i && req1_valid_i) begin
                grant_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant_id    = 1'b0;
`else
                grant_id    = ~last_grant;
`endif
            end else if (req0_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready_o = grant_valid && !grant_id;
    assign req1_ready_o = grant_valid &&  grant_id;

    assign sel_ctrl = grant_id ? req1_ctrl_i : req0_ctrl_i;
    assign sel_src1 = grant_id ? req1_src1_i : req0_src1_i;
    assign sel_src2 = grant_id ? req1_src2_i : req0_src2_i;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (grant_valid)  state_nxt = EXEC;
            EXEC: if (cnt == '0)    state_nxt = RESP;
            RESP: if (rsp_ready_i)  state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands stay latched after the op so the ALU inputs do not toggle between requests.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant   <= 1'b1;
            cnt          <= '0;
            alu_ctrl_o   <= '0;
            alu_src1_o   <= '0;
            alu_src2_o   <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_ctrl_o <= sel_ctrl;
                        alu_src1_o <= sel_src1;
                        alu_src2_o <= sel_src2;
                        rsp_id_o   <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= (sel_ctrl == CTRL_MUL) ? MUL_LOAD : '0;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        rsp_result_o <= alu_result_i;
                        rsp_zero_o   <= alu_zero_i;
                        rsp_valid_o  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: scoreboard of expected responses plus per-scenario tasks.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_alu_share_arbiter;

    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              req0_valid_i = 1'b0;
    logic              req0_ready_o;
    logic [3:0]        req0_ctrl_i = '0;
    logic [DATA_W-1:0] req0_src1_i = '0;
    logic [DATA_W-1:0] req0_src2_i = '0;
    logic              req1_valid_i = 1'b0;
    logic              req1_ready_o;
    logic [3:0]        req1_ctrl_i = '0;
    logic [DATA_W-1:0] req1_src1_i = '0;
    logic [DATA_W-1:0] req1_src2_i = '0;
    logic [3:0]        alu_ctrl_o;
    logic [DATA_W-1:0] alu_src1_o;
    logic [DATA_W-1:0] alu_src2_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic              rsp_id_o;
    logic [DATA_W-1:0] rsp_result_o;
    logic              rsp_zero_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] result;
        logic              zero;
    } rsp_t;

    rsp_t sb[$];

    alu_share_arbiter #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_ctrl_i  (req0_ctrl_i),
        .req0_src1_i  (req0_src1_i),
        .req0_src2_i  (req0_src2_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_ctrl_i  (req1_ctrl_i),
        .req1_src1_i  (req1_src1_i),
        .req1_src2_i  (req1_src2_i),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Environment ALU attached to the arbiter's ALU port.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [3:0] c,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a * b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
            4'd9:    return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        alu_result_i = alu_fn(alu_ctrl_o, alu_src1_o, alu_src2_o);
        alu_zero_i   = (alu_result_i == '0);
    end

    // Scoreboard: push on accept, pop on response handshake; sampled on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            n_checks++;
            if (req0_ready_o && req1_ready_o) begin
                n_fail++;
                $display("FAIL one_ready: ready0=%b ready1=%b, at most one expected", req0_ready_o, req1_ready_o);
            end
            if (req0_valid_i && req0_ready_o) begin
                rsp_t e;
                e.id     = 1'b0;
                e.result = alu_fn(req0_ctrl_i, req0_src1_i, req0_src2_i);
                e.zero   = (e.result == '0);
                sb.push_back(e);
            end
            if (req1_valid_i && req1_ready_o) begin
                rsp_t e;
                e.id     = 1'b1;
                e.result = alu_fn(req1_ctrl_i, req1_src1_i, req1_src2_i);
                e.zero   = (e.result == '0);
                sb.push_back(e);
            end
            if (rsp_valid_o && rsp_ready_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: response id=%0d result=%h with nothing outstanding", rsp_id_o, rsp_result_o);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    if ({rsp_id_o, rsp_result_o, rsp_zero_o} !== {e.id, e.result, e.zero}) begin
                        n_fail++;
                        $display("FAIL sb_rsp: got id=%0d result=%h zero=%b, expected id=%0d result=%h zero=%b",
                                 rsp_id_o, rsp_result_o, rsp_zero_o, e.id, e.result, e.zero);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_i = 1'b0;
        @(negedge clk_i);
        tick();
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({alu_ctrl_o, alu_src1_o, alu_src2_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: got ctrl=%h src1=%h src2=%h, expected all 0", alu_ctrl_o, alu_src1_o, alu_src2_o);
        end
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got valid=%b id=%b result=%h zero=%b, expected all 0",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        n_checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 00", {req0_ready_o, req1_ready_o});
        end
        tick();
        rst_i = 1'b1;
    endtask

    // ctrl=2, 5+7: one-cycle op, response two cycles after the ready cycle.
    task automatic test_basic();
        tick();
        req0_valid_i = 1'b1; req0_ctrl_i = 4'd2; req0_src1_i = 32'd5; req0_src2_i = 32'd7;
        @(negedge clk_i);
        n_checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_ready: got %b, expected 10", {req0_ready_o, req1_ready_o});
        end
        tick();
        req0_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, req0_ready_o, alu_ctrl_o, alu_src1_o, alu_src2_o} !== {1'b0, 1'b0, 4'd2, 32'd5, 32'd7}) begin
            n_fail++;
            $display("FAIL basic_exec: got valid=%b ready0=%b ctrl=%h src1=%h src2=%h, expected 0 0 2 5 7",
                     rsp_valid_o, req0_ready_o, alu_ctrl_o, alu_src1_o, alu_src2_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_rsp: got valid=%b id=%b result=%h zero=%b, expected 1 0 0000000c 0",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: rsp_valid got %b, expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_round_robin();
        int ids[$];
        int at[$];
        rst_i = 1'b0;
        rsp_ready_i  = 1'b1;
        req0_valid_i = 1'b1; req0_ctrl_i = 4'd2; req0_src1_i = 32'd100; req0_src2_i = 32'd23;
        req1_valid_i = 1'b1; req1_ctrl_i = 4'd6; req1_src1_i = 32'd50;  req1_src2_i = 32'd8;
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (req0_ready_o) begin
                ids.push_back(0); at.push_back(i);
            end else if (req1_ready_o) begin
                ids.push_back(1); at.push_back(i);
            end
        end
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        n_checks++;
        if (ids.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants, expected 4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                int exp_id;
`ifdef ALU_ARB_FIXED_PRIO_EN
                exp_id = 0;
`else
                exp_id = k % 2;
`endif
                n_checks++;
                if (ids[k] != exp_id || at[k] != 3 * k) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: got id=%0d cycle=%0d, expected id=%0d cycle=%0d",
                             k, ids[k], at[k], exp_id, 3 * k);
                end
            end
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_mul();
        tick();
        req1_valid_i = 1'b1; req1_ctrl_i = 4'd3; req1_src1_i = 32'd6; req1_src2_i = 32'd7;
        @(negedge clk_i);
        n_checks++;
        if ({req0_ready_o, req1_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL mul_ready: got %b, expected 01", {req0_ready_o, req1_ready_o});
        end
        tick();
        req1_valid_i = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({rsp_valid_o, alu_ctrl_o, alu_src1_o} !== {1'b0, 4'd3, 32'd6}) begin
                n_fail++;
                $display("FAIL mul_exec%0d: got valid=%b ctrl=%h src1=%h, expected 0 3 00000006",
                         k, rsp_valid_o, alu_ctrl_o, alu_src1_o);
            end
        end
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== {1'b1, 1'b1, 32'd42, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_rsp: got valid=%b id=%b result=%h zero=%b, expected 1 1 0000002a 0",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        tick();
        rsp_ready_i  = 1'b0;
        req0_valid_i = 1'b1; req0_ctrl_i = 4'd1; req0_src1_i = 32'hF0; req0_src2_i = 32'h0F;
        @(negedge clk_i);
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_ctrl_i = 4'd0; req1_src1_i = 32'hFF00; req1_src2_i = 32'h0FF0;
        @(negedge clk_i);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, req0_ready_o, req1_ready_o}
                    !== {1'b1, 1'b0, 32'hFF, 1'b0, 2'b00}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b id=%b result=%h zero=%b ready=%b%b, expected 1 0 000000ff 0 00",
                         k, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, req0_ready_o, req1_ready_o);
            end
        end
        tick();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        tick();
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, req1_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready1=%b, expected 0 1", rsp_valid_o, req1_ready_o);
        end
        tick();
        req1_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o} !== {1'b1, 1'b1, 32'h0F00}) begin
            n_fail++;
            $display("FAIL bp_next: got valid=%b id=%b result=%h, expected 1 1 00000f00",
                     rsp_valid_o, rsp_id_o, rsp_result_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_op();
        tick();
        req0_valid_i = 1'b1; req0_ctrl_i = 4'd3; req0_src1_i = 32'd3; req0_src2_i = 32'd3;
        @(negedge clk_i);
        tick();
        req0_valid_i = 1'b0;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if ({alu_ctrl_o, alu_src1_o, alu_src2_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o,
             req0_ready_o, req1_ready_o} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got ctrl=%h src1=%h src2=%h valid=%b id=%b result=%h zero=%b ready=%b%b, expected all 0",
                     alu_ctrl_o, alu_src1_o, alu_src2_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o,
                     req0_ready_o, req1_ready_o);
        end
        tick();
        rst_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (rsp_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_norsp%0d: rsp_valid got %b, expected 0", k, rsp_valid_o);
            end
        end
    endtask

    task automatic test_zero_flag();
        tick();
        req0_valid_i = 1'b1; req0_ctrl_i = 4'd6; req0_src1_i = 32'd9; req0_src2_i = 32'd9;
        @(negedge clk_i);
        tick();
        req0_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_rsp: got valid=%b id=%b result=%h zero=%b, expected 1 0 00000000 1",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_unlisted_code();
        tick();
        req1_valid_i = 1'b1; req1_ctrl_i = 4'd13; req1_src1_i = 32'h1234; req1_src2_i = 32'h5678;
        @(negedge clk_i);
        tick();
        req1_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, alu_ctrl_o} !== {1'b0, 4'd13}) begin
            n_fail++;
            $display("FAIL unl_exec: got valid=%b ctrl=%h, expected 0 d", rsp_valid_o, alu_ctrl_o);
        end
        @(negedge clk_i);
        n_checks++;
        if ({rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o} !== {1'b1, 1'b1, 32'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL unl_rsp: got valid=%b id=%b result=%h zero=%b, expected 1 1 00001234 0",
                     rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o);
        end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_mul();
        test_backpressure();
        test_reset_mid_op();
        test_zero_flag();
        test_unlisted_code();
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
